// File: rtl/minibyte_pkg.sv
// Shared constants for the minibyte MMIO timer: register offsets, CTRL/STATUS
// bit positions, reset values and CTRL write masks.
package minibyte_pkg;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_OVF   = 1;

    localparam logic [7:0] COMPARE_RESET = 8'hFF;

    // Bit 3 is reserved; PRESCALE bits are only storable when the prescaler exists.
    localparam logic [7:0] CTRL_WMASK_PRESCALE = 8'hF7;
    localparam logic [7:0] CTRL_WMASK_BASIC    = 8'h07;
    localparam logic [7:0] STATUS_MASK         = 8'h03;

endpackage

// File: rtl/minibyte_prescaler.sv
// Tick divider: one tick every divisor+1 enabled cycles, phase restartable.
// Only present when MINIBYTE_TIMER_PRESCALER_EN is defined.
`ifdef MINIBYTE_TIMER_PRESCALER_EN
module minibyte_prescaler (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable,
    input  logic       restart,
    input  logic [3:0] divisor,
    output logic       tick
);

    logic [3:0] phase_q;

    assign tick = enable && (phase_q == divisor);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            phase_q <= 4'd0;
        end else if (restart) begin
            phase_q <= 4'd0;
        end else if (enable) begin
            phase_q <= tick ? 4'd0 : phase_q + 4'd1;
        end
    end

endmodule
`endif

// File: rtl/minibyte_mmio_timer.sv
// Memory-mapped 8-bit compare timer (CTRL/COUNT/COMPARE/STATUS) with IRQ.
// Optional prescaler selected by MINIBYTE_TIMER_PRESCALER_EN.
module minibyte_mmio_timer #(
    parameter logic [6:0] BASE_ADDR = 7'h78
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] address,
    input  logic [7:0] data_in,
    input  logic       we_in,
    output logic [7:0] data_out,
    output logic       active_out,
    output logic       irq_out
);
    import minibyte_pkg::*;

    logic [7:0] ctrl_q, count_q, compare_q, status_q;
    logic [7:0] ctrl_d, count_d, compare_d, status_d, status_set;
    logic       irq_d;
    logic       tick;
    logic       wr_en, wr_ctrl, wr_count, wr_compare, wr_status;

    assign active_out = (address[6:2] == BASE_ADDR[6:2]);
    assign wr_en      = we_in && active_out;
    assign wr_ctrl    = wr_en && (address[1:0] == OFF_CTRL);
    assign wr_count   = wr_en && (address[1:0] == OFF_COUNT);
    assign wr_compare = wr_en && (address[1:0] == OFF_COMPARE);
    assign wr_status  = wr_en && (address[1:0] == OFF_STATUS);

`ifdef MINIBYTE_TIMER_PRESCALER_EN
    localparam logic [7:0] CTRL_WMASK = CTRL_WMASK_PRESCALE;

    minibyte_prescaler u_prescaler (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .enable  (ctrl_q[CTRL_EN]),
        .restart (wr_ctrl),
        .divisor (ctrl_q[7:4]),
        .tick    (tick)
    );
`else
    localparam logic [7:0] CTRL_WMASK = CTRL_WMASK_BASIC;

    assign tick = ctrl_q[CTRL_EN];
`endif

    always_comb begin
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_set = 8'h00;

        if (tick) begin
            if (count_q == compare_q) begin
                status_set[STATUS_MATCH] = 1'b1;
                if (ctrl_q[CTRL_AUTORELOAD])
                    count_d = 8'h00;
                else
                    ctrl_d[CTRL_EN] = 1'b0;
            end else begin
                count_d = count_q + 8'd1;
                if (count_q == 8'hFF)
                    status_set[STATUS_OVF] = 1'b1;
            end
        end

        // CPU writes override the tick's update of the same register.
        if (wr_ctrl)
            ctrl_d = data_in & CTRL_WMASK;
        if (wr_count)
            count_d = data_in;
        if (wr_compare)
            compare_d = data_in;

        status_d = status_q;
        if (wr_status)
            status_d = status_q & ~data_in;
        // A flag being set wins over a same-cycle write-1-to-clear.
        status_d = (status_d | status_set) & STATUS_MASK;

        irq_d = ctrl_d[CTRL_IRQEN] & status_d[STATUS_MATCH];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ctrl_q    <= 8'h00;
            count_q   <= 8'h00;
            compare_q <= COMPARE_RESET;
            status_q  <= 8'h00;
            irq_out   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            irq_out   <= irq_d;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (active_out) begin
            case (address[1:0])
                OFF_CTRL:    data_out = ctrl_q;
                OFF_COUNT:   data_out = count_q;
                OFF_COMPARE: data_out = compare_q;
                OFF_STATUS:  data_out = status_q;
                default:     data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/minibyte_mmio_timer.md
MINIBYTE_MMIO_TIMER -- requirements
Module: minibyte_mmio_timer

Interface
- REQ-001: The block SHALL have a parameter BASE_ADDR, default 7'h78, giving the 4-byte-aligned base of its register window (bits [1:0] ignored).
- REQ-002: The block SHALL have port clk_in, input, 1, the single clock; every flop is rising-edge.
- REQ-003: The block SHALL have port rst_in, input, 1, reset; asynchronous, active-high.
- REQ-004: The block SHALL have port address, input, 7, the CPU address bus.
- REQ-005: The block SHALL have port data_in, input, 8, the CPU write data (CPU data_out).
- REQ-006: The block SHALL have port we_in, input, 1, the CPU write enable.
- REQ-007: The block SHALL have port data_out, output, 8, read data to the top-level input mux.
- REQ-008: The block SHALL have port active_out, output, 1, high while the address hits the window; it is the input-mux select qualifier.
- REQ-009: The block SHALL have port irq_out, output, 1, registered interrupt level.

Function
- REQ-010: active_out SHALL be combinational: address[6:2] == BASE_ADDR[6:2].
- REQ-011: The register map SHALL be: offset 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
- REQ-012: CTRL SHALL hold: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, bits[7:4] PRESCALE, bit3 reserved (reads 0).
- REQ-013: data_out SHALL be a combinational read of the addressed register, and 8'h00 when active_out is low.
- REQ-014: A register write SHALL occur on the clock edge where we_in && active_out; STATUS writes are write-1-to-clear.
- REQ-015: A tick SHALL be a single-cycle internal strobe, generated only while EN=1.
- REQ-016: On a tick with COUNT == COMPARE, STATUS[0] (MATCH) SHALL be set.
- REQ-017: On that tick, COUNT SHALL go to 0 if AUTORELOAD=1; otherwise EN SHALL clear (one-shot) and COUNT SHALL hold.
- REQ-018: On a tick with COUNT != COMPARE, COUNT SHALL increment modulo 256.
- REQ-019: On the wrap from 8'hFF to 8'h00 (COMPARE != 8'hFF), STATUS[1] (OVF) SHALL be set.
- REQ-020: Latency: the first increment SHALL occur on the first tick edge after the edge that writes EN=1.
- REQ-021: A CPU write to COUNT or CTRL in the same cycle as a tick SHALL win over the tick's update.
- REQ-022: A STATUS flag set and W1C clear in the same cycle SHALL leave the flag set.
- REQ-023: irq_out SHALL be registered: on each edge it takes IRQEN & (next MATCH), so it asserts one cycle after the setting edge.
- REQ-024: STATUS bits[7:2] SHALL read 0.

Reset
- REQ-025: Asserting rst_in at any time, including mid-count, SHALL immediately clear CTRL, COUNT, STATUS, the prescaler and irq_out to 0.
- REQ-026: Reset SHALL load COMPARE to 8'hFF.
- REQ-027: While reset is asserted, data_out SHALL reflect the reset register values; active_out SHALL stay combinational.

Configuration
- REQ-028: Macro MINIBYTE_TIMER_PRESCALER_EN defined: a 4-bit prescaler SHALL produce a tick every PRESCALE+1 enabled cycles.
- REQ-029: With the macro defined, the prescaler SHALL restart at 0 on any CTRL write.
- REQ-030: Macro undefined: a tick SHALL occur every cycle EN=1, PRESCALE bits SHALL be unwritable, and they SHALL read 0.

Structure
- REQ-031: Shared package minibyte_pkg SHALL hold the register offset constants, the CTRL/STATUS bit index constants and the COMPARE reset value.
- REQ-032: The prescaler SHALL be sub-module minibyte_prescaler (inputs: enable, restart, divisor; output: tick), instantiated only under the macro.

Verification
- REQ-033: Reset, then read offsets 0-3 at BASE_ADDR -> 00, 00, FF, 00; an address outside the window (7'h77) -> active_out=0, data_out=00.
- REQ-034: Write COMPARE=03, CTRL=07 (no prescaler) -> COUNT 1,2,3,0 sequence; MATCH set on the 4th tick edge; irq_out high one cycle later; W1C 01 to STATUS -> irq_out low next cycle.
- REQ-035: CTRL=01 (one-shot), COMPARE=02 -> COUNT stops at 02; EN reads 0; MATCH=1.
- REQ-036: COMPARE=FF unchanged, write COUNT=FE, then CTRL=01 and COMPARE=10 -> wrap FF->00 sets OVF, then matches at 10.
- REQ-037: Write COUNT=55 on a tick cycle -> COUNT reads 55 (write wins); simultaneous MATCH set with W1C -> MATCH stays 1.
- REQ-038: With the macro, CTRL=0x33 (PRESCALE=3, autoreload) -> one increment per 4 cycles; rst_in pulse mid-count -> all registers back to reset values asynchronously.
